// File: rtl/rst_strap_ctrl.sv
// rst_strap_ctrl: reset and boot-strap conditioning between board pins and
// the chip-top system reset and strap inputs.
// - Merges button, JTAG and GPIO0 reset requests into one active-low reset.
// - Synchronises every request and both straps.
// - Debounces the button.
// - Stretches the released reset by StretchCycles.
// - Latches both straps at each reset release.
// Optional feature macro: RST_STRAP_CTRL_GPIO_RST_EN. When it is defined,
// gpio_rst_ni is a reset request. When it is undefined, gpio_rst_ni is ignored.
module rst_strap_ctrl #(
   parameter int unsigned SyncStages     = 2,
   parameter int unsigned DebounceCycles = 16,
   parameter int unsigned StretchCycles  = 32
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       btn_rst_ni,
   input  logic       jtag_srst_ni,
   input  logic       gpio_rst_ni,
   input  logic       strap_spi_i,
   input  logic       strap_bootstrap_i,
   output logic       rst_sys_no,
   output logic       strap_valid_o,
   output logic       strap_spi_o,
   output logic       strap_bootstrap_o,
   output logic [2:0] rst_cause_o
);

   localparam int unsigned IdxBtn  = 0;
   localparam int unsigned IdxJtag = 1;
   localparam int unsigned IdxSpi  = 2;
   localparam int unsigned IdxBoot = 3;
`ifdef RST_STRAP_CTRL_GPIO_RST_EN
   localparam int unsigned IdxGpio = 4;
   localparam int unsigned NumSync = 5;
`else
   localparam int unsigned NumSync = 4;
`endif
   localparam int unsigned DbW = $clog2(DebounceCycles) + 1;
   localparam int unsigned StW = $clog2(StretchCycles) + 1;

   typedef enum logic [1:0] {ST_HOLD, ST_RUN, ST_ASSERT} state_e;

   logic [NumSync-1:0] async_in;
   logic [NumSync-1:0] sync_q [SyncStages];
   logic [NumSync-1:0] sync_out;
   logic               btn_sync, jtag_sync, gpio_sync, spi_sync, boot_sync;
   logic               btn_db_q;
   logic [DbW-1:0]     db_cnt_q;
   logic               req;

   state_e             state_q, state_d;
   logic [StW-1:0]     cnt_q, cnt_d;
   logic               rst_q, rst_d;
   logic               valid_q, valid_d;
   logic               spi_q, spi_d;
   logic               boot_q, boot_d;
   logic [2:0]         cause_q, cause_d;

`ifdef RST_STRAP_CTRL_GPIO_RST_EN
   assign async_in  = {gpio_rst_ni, strap_bootstrap_i, strap_spi_i, jtag_srst_ni, btn_rst_ni};
   assign gpio_sync = sync_out[IdxGpio];
`else
   logic unused_gpio;
   assign unused_gpio = gpio_rst_ni;
   assign async_in    = {strap_bootstrap_i, strap_spi_i, jtag_srst_ni, btn_rst_ni};
   assign gpio_sync   = 1'b1;
`endif

   assign sync_out  = sync_q[SyncStages-1];
   assign btn_sync  = sync_out[IdxBtn];
   assign jtag_sync = sync_out[IdxJtag];
   assign spi_sync  = sync_out[IdxSpi];
   assign boot_sync = sync_out[IdxBoot];

   // Synchroniser chain for all asynchronous inputs. All flops reset to 1.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < SyncStages; i++) sync_q[i] <= '1;
      end else begin
         sync_q[0] <= async_in;
         for (int unsigned i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // Button debounce. The button value flips only after DebounceCycles
   // consecutive cycles in which the synced button differs from it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         btn_db_q <= 1'b1;
         db_cnt_q <= '0;
      end else if (btn_sync != btn_db_q) begin
         if (db_cnt_q == DbW'(DebounceCycles - 1)) begin
            btn_db_q <= btn_sync;
            db_cnt_q <= '0;
         end else begin
            db_cnt_q <= db_cnt_q + DbW'(1);
         end
      end else begin
         db_cnt_q <= '0;
      end
   end

   assign req = ~btn_db_q | ~jtag_sync | ~gpio_sync;

   // State register and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_HOLD;
         cnt_q   <= '0;
         rst_q   <= 1'b0;
         valid_q <= 1'b0;
         spi_q   <= 1'b0;
         boot_q  <= 1'b0;
         cause_q <= 3'b000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rst_q   <= rst_d;
         valid_q <= valid_d;
         spi_q   <= spi_d;
         boot_q  <= boot_d;
         cause_q <= cause_d;
      end
   end

   // Next-state logic. Outputs change only on the transition edges, so each
   // transition writes the value its destination state presents.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rst_d   = rst_q;
      valid_d = valid_q;
      spi_d   = spi_q;
      boot_d  = boot_q;
      cause_d = cause_q;
      unique case (state_q)
         ST_HOLD: begin
            rst_d   = 1'b0;
            valid_d = 1'b0;
            if (req) begin
               state_d = ST_ASSERT;
               cnt_d   = '0;
            end else if (cnt_q == StW'(StretchCycles - 1)) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               rst_d   = 1'b1;
               valid_d = 1'b1;
               spi_d   = spi_sync;
               boot_d  = boot_sync;
            end else begin
               cnt_d = cnt_q + StW'(1);
            end
         end
         ST_RUN: begin
            rst_d = 1'b1;
            if (req) begin
               state_d = ST_ASSERT;
               rst_d   = 1'b0;
               valid_d = 1'b0;
               cause_d = {~gpio_sync, ~jtag_sync, ~btn_db_q};
            end
         end
         ST_ASSERT: begin
            rst_d   = 1'b0;
            valid_d = 1'b0;
            if (!req) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            rst_d   = 1'b0;
            valid_d = 1'b0;
         end
      endcase
   end

   assign rst_sys_no        = rst_q;
   assign strap_valid_o     = valid_q;
   assign strap_spi_o       = spi_q;
   assign strap_bootstrap_o = boot_q;
   assign rst_cause_o       = cause_q;

endmodule

// File: tb/tb_rst_strap_ctrl.sv
// Directed bench for rst_strap_ctrl with the default parameters.
// A vector table covers power-on, JTAG reset, button debounce and strap
// re-sampling. Hand-written sequences cover a request during HOLD and an
// rst_ni assertion in the middle of operation.
module tb_rst_strap_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       btn_rst_ni = 1'b1;
   logic       jtag_srst_ni = 1'b1;
   logic       gpio_rst_ni = 1'b1;
   logic       strap_spi_i = 1'b1;
   logic       strap_bootstrap_i = 1'b1;
   logic       rst_sys_no;
   logic       strap_valid_o;
   logic       strap_spi_o;
   logic       strap_bootstrap_o;
   logic [2:0] rst_cause_o;

   int checks = 0;
   int errors = 0;

   rst_strap_ctrl #(
      .SyncStages    (2),
      .DebounceCycles(16),
      .StretchCycles (32)
   ) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .btn_rst_ni       (btn_rst_ni),
      .jtag_srst_ni     (jtag_srst_ni),
      .gpio_rst_ni      (gpio_rst_ni),
      .strap_spi_i      (strap_spi_i),
      .strap_bootstrap_i(strap_bootstrap_i),
      .rst_sys_no       (rst_sys_no),
      .strap_valid_o    (strap_valid_o),
      .strap_spi_o      (strap_spi_o),
      .strap_bootstrap_o(strap_bootstrap_o),
      .rst_cause_o      (rst_cause_o)
   );

   // Free-running clock with a period of 10 time units.
   always #5 clk_i = ~clk_i;

   typedef struct {
      string      name;
      logic       btn, jtag, gpio, spi, boot;
      int         n;
      logic       rst, valid, spi_o, boot_o;
      logic [2:0] cause;
   } vec_t;

   vec_t vecs[18];

   function automatic vec_t mk(string nm, logic b, logic j, logic g, logic s, logic bt, int n,
                               logic r, logic v, logic so, logic bo, logic [2:0] c);
      vec_t t;
      t.name = nm; t.btn = b; t.jtag = j; t.gpio = g; t.spi = s; t.boot = bt; t.n = n;
      t.rst = r; t.valid = v; t.spi_o = so; t.boot_o = bo; t.cause = c;
      return t;
   endfunction

   task automatic chk(string nm, logic r, logic v, logic so, logic bo, logic [2:0] c);
      logic [6:0] act, exp;
      act = {rst_sys_no, strap_valid_o, strap_spi_o, strap_bootstrap_o, rst_cause_o};
      exp = {r, v, so, bo, c};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: {rst,valid,spi,boot,cause} got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic step(int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   logic       exp_spi_o;
   logic [2:0] exp_cause;

   initial begin
      vecs[0]  = mk("por_hold",      1,1,1,1,1, 31, 0,0,0,0,3'b000);
      vecs[1]  = mk("por_run",       1,1,1,1,1,  1, 1,1,1,1,3'b000);
      vecs[2]  = mk("jtag_sync_lag", 1,0,1,1,1,  2, 1,1,1,1,3'b000);
      vecs[3]  = mk("jtag_assert",   1,0,1,1,1,  1, 0,0,1,1,3'b010);
      vecs[4]  = mk("jtag_held",     1,0,1,1,1,  2, 0,0,1,1,3'b010);
      vecs[5]  = mk("jtag_stretch",  1,1,1,1,1, 34, 0,0,1,1,3'b010);
      vecs[6]  = mk("jtag_release",  1,1,1,1,1,  1, 1,1,1,1,3'b010);
      vecs[7]  = mk("btn_bounce",    0,1,1,1,1, 10, 1,1,1,1,3'b010);
      vecs[8]  = mk("btn_bounce_rel",1,1,1,1,1, 30, 1,1,1,1,3'b010);
      vecs[9]  = mk("btn_debounce",  0,1,1,1,1, 18, 1,1,1,1,3'b010);
      vecs[10] = mk("btn_assert",    0,1,1,1,1,  1, 0,0,1,1,3'b001);
      vecs[11] = mk("btn_held",      0,1,1,1,1,  1, 0,0,1,1,3'b001);
      vecs[12] = mk("btn_stretch",   1,1,1,1,1, 50, 0,0,1,1,3'b001);
      vecs[13] = mk("btn_release",   1,1,1,1,1,  1, 1,1,1,1,3'b001);
      vecs[14] = mk("strap_in_run",  1,1,1,0,1,  5, 1,1,1,1,3'b001);
`ifdef RST_STRAP_CTRL_GPIO_RST_EN
      vecs[15] = mk("gpio_assert",   1,1,0,0,1,  3, 0,0,1,1,3'b100);
      vecs[16] = mk("gpio_stretch",  1,1,1,0,1, 34, 0,0,1,1,3'b100);
      vecs[17] = mk("gpio_resample", 1,1,1,0,1,  1, 1,1,0,1,3'b100);
      exp_spi_o = 1'b0;
      exp_cause = 3'b100;
`else
      vecs[15] = mk("gpio_ignored",  1,1,0,0,1,  3, 1,1,1,1,3'b001);
      vecs[16] = mk("gpio_ign_rel",  1,1,1,0,1, 34, 1,1,1,1,3'b001);
      vecs[17] = mk("gpio_no_reset", 1,1,1,0,1,  1, 1,1,1,1,3'b001);
      exp_spi_o = 1'b1;
      exp_cause = 3'b001;
`endif

      // Reset state while rst_ni is held low.
      step(3);
      chk("reset_state", 0,0,0,0,3'b000);
      // Release rst_ni just after an edge so the next edge is stretch edge 1.
      rst_ni = 1'b1;

      for (int i = 0; i < 18; i++) begin
         btn_rst_ni        = vecs[i].btn;
         jtag_srst_ni      = vecs[i].jtag;
         gpio_rst_ni       = vecs[i].gpio;
         strap_spi_i       = vecs[i].spi;
         strap_bootstrap_i = vecs[i].boot;
         step(vecs[i].n);
         chk(vecs[i].name, vecs[i].rst, vecs[i].valid, vecs[i].spi_o, vecs[i].boot_o,
             vecs[i].cause);
      end

      // A request arriving in HOLD must go through ASSERT and restart the full stretch.
      chk("pre_hold_seq", 1,1,exp_spi_o,1,exp_cause);
      jtag_srst_ni = 1'b0;
      step(3);
      chk("hold_seq_assert", 0,0,exp_spi_o,1,3'b010);
      jtag_srst_ni = 1'b1;
      step(3);   // ASSERT -> HOLD edge, counter = 0
      step(20);  // HOLD counter = 20
      chk("hold_cycle20", 0,0,exp_spi_o,1,3'b010);
      jtag_srst_ni = 1'b0;
      step(3);
      chk("hold_req_assert", 0,0,exp_spi_o,1,3'b010);
      step(2);
      jtag_srst_ni = 1'b1;
      step(34);
      chk("hold_restart_low", 0,0,exp_spi_o,1,3'b010);
      step(1);
      chk("hold_restart_rel", 1,1,0,1,3'b010);

      // Button and JTAG timed so both are low at the RUN -> ASSERT edge.
      btn_rst_ni = 1'b0;
      step(16);
      jtag_srst_ni = 1'b0;
      step(3);
      chk("dual_cause", 0,0,0,1,3'b011);

      // rst_ni asserted mid-cycle forces every output to reset values without a clock edge.
      #3 rst_ni = 1'b0;
      #1;
      chk("async_reset", 0,0,0,0,3'b000);
      btn_rst_ni        = 1'b1;
      jtag_srst_ni      = 1'b1;
      strap_spi_i       = 1'b0;
      strap_bootstrap_i = 1'b0;
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      step(31);
      chk("por2_hold", 0,0,0,0,3'b000);
      step(1);
      chk("por2_run", 1,1,0,0,3'b000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
